// File: rtl/dma_seq_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dma_seq_pkg                                                      |
// | Shared state encoding and defaults for the cache-line sequencer. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package dma_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEFAULT_MAX_OUTSTANDING = 16;

endpackage
`default_nettype wire

// File: rtl/dma_cl_sequencer_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dma_cl_sequencer_if                                              |
// | Host-control and CCI-P shim signals of the line-copy sequencer.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface dma_cl_sequencer_if #(
  parameter int CL_ADDR_WIDTH = 42
);

  logic                     start;
  logic [CL_ADDR_WIDTH-1:0] src_addr;
  logic [CL_ADDR_WIDTH-1:0] dst_addr;
  logic [CL_ADDR_WIDTH-1:0] size;
  logic                     busy;
  logic                     done;
  logic                     err;
  logic                     rd_req_valid;
  logic [CL_ADDR_WIDTH-1:0] rd_req_addr;
  logic                     rd_req_ready;
  logic                     rd_rsp_valid;
  logic                     wr_req_valid;
  logic [CL_ADDR_WIDTH-1:0] wr_req_addr;
  logic                     wr_req_ready;
  logic                     wr_rsp_valid;

  // master = sequencer side, slave = host registers plus shim
  modport master (
    input  start, src_addr, dst_addr, size,
    input  rd_req_ready, rd_rsp_valid, wr_req_ready, wr_rsp_valid,
    output busy, done, err,
    output rd_req_valid, rd_req_addr, wr_req_valid, wr_req_addr
  );

  modport slave (
    output start, src_addr, dst_addr, size,
    output rd_req_ready, rd_rsp_valid, wr_req_ready, wr_rsp_valid,
    input  busy, done, err,
    input  rd_req_valid, rd_req_addr, wr_req_valid, wr_req_addr
  );

endinterface
`default_nettype wire

// File: rtl/dma_updown_cnt.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dma_updown_cnt                                                   |
// | Up/down occupancy counter; inc and dec together hold the value.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module dma_updown_cnt #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] value
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      value <= '0;
    end else if (inc && !dec) begin
      value <= value + WIDTH'(1);
    end else if (dec && !inc) begin
      value <= value - WIDTH'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/dma_cl_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | dma_cl_sequencer                                                 |
// | Paces one cache-line copy job: reads, buffered writes, drain.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module dma_cl_sequencer
  import dma_seq_pkg::*;
#(
  parameter int CL_ADDR_WIDTH   = 42,
  parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING,
  parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic               clk,
  input  logic               rst,
  dma_cl_sequencer_if.master bus
);

  typedef logic [CL_ADDR_WIDTH-1:0] addr_t;

  state_t r_state;
  state_t w_state_nxt;

  addr_t r_src_base;
  addr_t r_dst_base;
  addr_t r_size;
  addr_t r_rd_issued;
  addr_t r_rd_rsp_cnt;
  addr_t r_wr_issued;
  addr_t r_wr_rsp_cnt;
  logic  r_err;

  logic [CNT_WIDTH-1:0] w_inflight;
  logic [CNT_WIDTH-1:0] w_buffered;

  logic w_run;
  logic w_busy;
  logic w_accept;
  logic w_rd_valid;
  logic w_wr_valid;
  logic w_rd_fire;
  logic w_wr_fire;
  logic w_rd_rsp_ok;
  logic w_wr_rsp_ok;
  logic w_err_set;

  assign w_run      = (r_state == RUN);
  assign w_busy     = (r_state == RUN) || (r_state == DRAIN);
  assign w_accept   = ((r_state == IDLE) || (r_state == DONE)) && bus.start;

  // Depend only on registered state, so valid and address hold while stalled
  assign w_rd_valid = w_run && (r_rd_issued < r_size) &&
                      (w_inflight < CNT_WIDTH'(MAX_OUTSTANDING));
  assign w_wr_valid = w_run && (w_buffered != '0);
  assign w_rd_fire  = w_rd_valid && bus.rd_req_ready;
  assign w_wr_fire  = w_wr_valid && bus.wr_req_ready;

  // A response is legal only during a job and only if a request is still owed
  assign w_rd_rsp_ok = bus.rd_rsp_valid && w_busy && (r_rd_rsp_cnt != r_rd_issued);
  assign w_wr_rsp_ok = bus.wr_rsp_valid && w_busy && (r_wr_rsp_cnt != r_wr_issued);
  assign w_err_set   = (bus.rd_rsp_valid && !w_rd_rsp_ok) ||
                       (bus.wr_rsp_valid && !w_wr_rsp_ok);

  dma_updown_cnt #(.WIDTH(CNT_WIDTH)) u_inflight (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_accept),
    .inc   (w_rd_fire),
    .dec   (w_wr_fire),
    .value (w_inflight)
  );

  dma_updown_cnt #(.WIDTH(CNT_WIDTH)) u_buffered (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_accept),
    .inc   (w_rd_rsp_ok),
    .dec   (w_wr_fire),
    .value (w_buffered)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Transitions look at next-cycle counts so done lands one cycle after the last response
  always_comb begin
    w_state_nxt      = r_state;
    bus.busy         = w_busy;
    bus.done         = (r_state == DONE);
    bus.err          = r_err;
    bus.rd_req_valid = w_rd_valid;
    bus.rd_req_addr  = r_src_base + r_rd_issued;
    bus.wr_req_valid = w_wr_valid;
    bus.wr_req_addr  = r_dst_base + r_wr_issued;
    case (r_state)
      IDLE, DONE: begin
        if (bus.start) begin
          w_state_nxt = (bus.size == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if ((r_wr_issued + addr_t'(w_wr_fire)) == r_size) begin
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if ((r_wr_rsp_cnt + addr_t'(w_wr_rsp_ok)) == r_size) begin
          w_state_nxt = DONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_src_base   <= '0;
      r_dst_base   <= '0;
      r_size       <= '0;
      r_rd_issued  <= '0;
      r_rd_rsp_cnt <= '0;
      r_wr_issued  <= '0;
      r_wr_rsp_cnt <= '0;
      r_err        <= 1'b0;
    end else if (w_accept) begin
      r_src_base   <= bus.src_addr;
      r_dst_base   <= bus.dst_addr;
      r_size       <= bus.size;
      r_rd_issued  <= '0;
      r_rd_rsp_cnt <= '0;
      r_wr_issued  <= '0;
      r_wr_rsp_cnt <= '0;
      r_err        <= w_err_set;
    end else begin
      if (w_rd_fire) begin
        r_rd_issued <= r_rd_issued + addr_t'(1);
      end
      if (w_rd_rsp_ok) begin
        r_rd_rsp_cnt <= r_rd_rsp_cnt + addr_t'(1);
      end
      if (w_wr_fire) begin
        r_wr_issued <= r_wr_issued + addr_t'(1);
      end
      if (w_wr_rsp_ok) begin
        r_wr_rsp_cnt <= r_wr_rsp_cnt + addr_t'(1);
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dma_cl_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_dma_cl_sequencer                                              |
// | Directed bench with a small shim model for the line sequencer.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_dma_cl_sequencer;

  localparam int AW   = 42;
  localparam int MAXO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dma_cl_sequencer_if #(.CL_ADDR_WIDTH(AW)) ifc ();

  dma_cl_sequencer #(.CL_ADDR_WIDTH(AW), .MAX_OUTSTANDING(MAXO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [AW-1:0] job_src, job_dst, job_size, prev_addr;
  int  rd_cnt = 0, wr_cnt = 0, rd_rsp_sent = 0, wr_rsp_sent = 0;
  int  infl_model = 0, buf_model = 0, max_infl = 0;
  int  model_bad = 0, hold_bad = 0, triple = 0, last_wr_rsp_cyc = 0;
  int  lat = 1, rd_hold_until = 0;
  int  rd_due[$];
  int  wr_due[$];
  bit  rd_alt = 1'b0, force_rd = 1'b0, force_wr = 1'b0, prev_stall = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Called at a negedge: plays the shim for the coming posedge, then waits one cycle
  task automatic drive();
    logic          rfire, wfire, rr, wr;
    logic [AW-1:0] exp_addr;
    if (int'(dut.w_inflight) != infl_model || int'(dut.w_buffered) != buf_model) model_bad++;
    if (prev_stall && (!ifc.rd_req_valid || ifc.rd_req_addr != prev_addr)) hold_bad++;
    ifc.rd_req_ready = rd_alt ? (cyc % 2 == 0) : 1'b1;
    ifc.wr_req_ready = 1'b1;
    rfire = ifc.rd_req_valid && ifc.rd_req_ready;
    wfire = ifc.wr_req_valid && ifc.wr_req_ready;
    if (rfire) begin
      exp_addr = job_src + AW'(rd_cnt);
      check_val("rd_addr", 64'(ifc.rd_req_addr), 64'(exp_addr));
      rd_cnt++;
      rd_due.push_back(cyc + lat);
    end
    if (wfire) begin
      exp_addr = job_dst + AW'(wr_cnt);
      check_val("wr_addr", 64'(ifc.wr_req_addr), 64'(exp_addr));
      wr_cnt++;
      wr_due.push_back(cyc + lat);
    end
    rr = (rd_due.size() > 0) && (rd_due[0] <= cyc) && (cyc >= rd_hold_until);
    wr = (wr_due.size() > 0) && (wr_due[0] <= cyc);
    if (rr) begin
      void'(rd_due.pop_front());
      rd_rsp_sent++;
    end
    if (wr) begin
      void'(wr_due.pop_front());
      wr_rsp_sent++;
      last_wr_rsp_cyc = cyc;
    end
    ifc.rd_rsp_valid = rr || force_rd;
    ifc.wr_rsp_valid = wr || force_wr;
    if (rfire && rr && wfire) triple++;
    infl_model = infl_model + int'(rfire) - int'(wfire);
    buf_model  = buf_model + int'(rr) - int'(wfire);
    if (infl_model > max_infl) max_infl = infl_model;
    prev_stall = ifc.rd_req_valid && !ifc.rd_req_ready;
    prev_addr  = ifc.rd_req_addr;
    @(negedge clk);
    cyc++;
    ifc.rd_rsp_valid = 1'b0;
    ifc.wr_rsp_valid = 1'b0;
  endtask

  task automatic clear_model();
    rd_cnt = 0; wr_cnt = 0; rd_rsp_sent = 0; wr_rsp_sent = 0;
    infl_model = 0; buf_model = 0; max_infl = 0;
    model_bad = 0; hold_bad = 0; triple = 0; last_wr_rsp_cyc = -1;
    prev_stall = 1'b0;
    rd_due.delete();
    wr_due.delete();
  endtask

  task automatic check_reset_outputs();
    check_val("rst_busy",   64'(ifc.busy), 64'd0);
    check_val("rst_done",   64'(ifc.done), 64'd0);
    check_val("rst_err",    64'(ifc.err), 64'd0);
    check_val("rst_rd_vld", 64'(ifc.rd_req_valid), 64'd0);
    check_val("rst_wr_vld", 64'(ifc.wr_req_valid), 64'd0);
    check_val("rst_rd_adr", 64'(ifc.rd_req_addr), 64'd0);
    check_val("rst_wr_adr", 64'(ifc.wr_req_addr), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ifc.start = 1'b0;
    @(negedge clk);
    cyc++;
    rst = 1'b0;
    clear_model();
  endtask

  task automatic start_job(input logic [AW-1:0] src, input logic [AW-1:0] dst,
                           input logic [AW-1:0] sz, input int l, input int hold, input bit alt);
    clear_model();
    job_src = src; job_dst = dst; job_size = sz;
    lat = l; rd_alt = alt; rd_hold_until = cyc + hold;
    ifc.start = 1'b1; ifc.src_addr = src; ifc.dst_addr = dst; ifc.size = sz;
    drive();
    ifc.start = 1'b0;
    check_val("acc_err",    64'(ifc.err), 64'd0);
    check_val("acc_done",   64'(ifc.done), 64'(sz == '0));
    check_val("acc_busy",   64'(ifc.busy), 64'(sz != '0));
    check_val("acc_rd_vld", 64'(ifc.rd_req_valid), 64'(sz != '0));
  endtask

  task automatic finish_job(input int hold_chk);
    for (int k = 0; k < 3000; k++) begin
      if (ifc.done) break;
      if (hold_chk > 0 && cyc == hold_chk) begin
        check_val("bp_rd_cnt", 64'(rd_cnt), 64'(MAXO));
        check_val("bp_rd_vld", 64'(ifc.rd_req_valid), 64'd0);
      end
      drive();
    end
    check_val("done",        64'(ifc.done), 64'd1);
    check_val("rd_count",    64'(rd_cnt), 64'(job_size));
    check_val("wr_count",    64'(wr_cnt), 64'(job_size));
    check_val("wr_rsp_cnt",  64'(wr_rsp_sent), 64'(job_size));
    if (job_size != '0) check_val("done_latency", 64'(cyc - last_wr_rsp_cyc), 64'd1);
    check_val("job_err",     64'(ifc.err), 64'd0);
    check_val("cnt_model",   64'(model_bad), 64'd0);
    check_val("rd_hold",     64'(hold_bad), 64'd0);
  endtask

  initial begin
    ifc.start = 1'b0; ifc.src_addr = '0; ifc.dst_addr = '0; ifc.size = '0;
    ifc.rd_req_ready = 1'b0; ifc.wr_req_ready = 1'b0;
    ifc.rd_rsp_valid = 1'b0; ifc.wr_rsp_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset_outputs();

    // basic copy
    start_job(42'h100, 42'h200, 42'd4, 3, 0, 1'b0);
    finish_job(0);

    // zero size, then restart from DONE
    start_job(42'h300, 42'h400, 42'd0, 3, 0, 1'b0);
    finish_job(0);
    check_val("zero_wr_vld", 64'(ifc.wr_req_valid), 64'd0);
    start_job(42'h500, 42'h600, 42'd2, 2, 0, 1'b0);
    finish_job(0);

    // read issue, read response and write issue all in one cycle
    start_job(42'h1000, 42'h2000, 42'd8, 1, 0, 1'b0);
    finish_job(0);
    check_val("triple_seen", 64'(triple > 0), 64'd1);

    // read responses withheld: issue must stop at buffer depth
    start_job(42'h4000, 42'h8000, 42'd40, 3, 50, 1'b0);
    finish_job(cyc + 39);
    check_val("bp_max_infl", 64'(max_infl), 64'(MAXO));

    // stray write response in DONE is sticky until the next start
    force_wr = 1'b1;
    drive();
    force_wr = 1'b0;
    check_val("err_set", 64'(ifc.err), 64'd1);
    drive();
    check_val("err_sticky", 64'(ifc.err), 64'd1);

    // address wrap with a stalling read shim
    start_job({AW{1'b1}} - 42'd1, 42'h10, 42'd4, 2, 0, 1'b1);
    finish_job(0);

    // reset on the 5th RUN cycle
    start_job(42'h700, 42'h900, 42'd10, 3, 0, 1'b0);
    repeat (4) drive();
    do_reset();
    check_reset_outputs();
    force_rd = 1'b1;
    drive();
    force_rd = 1'b0;
    check_val("err_idle_rsp", 64'(ifc.err), 64'd1);
    start_job(42'hA00, 42'hB00, 42'd3, 3, 0, 1'b0);
    finish_job(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dma_cl_sequencer.md
Name: dma_cl_sequencer

Overview:
- Sequences one cache-line copy job of `size` lines from `src_addr` to `dst_addr`.
- Issues read requests, tracks outstanding reads and buffered lines, issues write requests as data lands, then waits for all write responses and reports completion.
- Sits between the AFU host-control registers and the CCI-P request/response shim.
- Owns read/write pacing so the external line buffer (depth MAX_OUTSTANDING) can never overflow.

Parameters:
- CL_ADDR_WIDTH, 42: width of cache-line addresses and of `size`.
- MAX_OUTSTANDING, 16: maximum lines read but not yet write-issued; equals external buffer depth; power of two, ≥2.
- CNT_WIDTH, $clog2(MAX_OUTSTANDING)+1: width of the credit/occupancy counters.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle job launch; sampled only in IDLE or DONE.
- src_addr  in  CL_ADDR_WIDTH  first source line address; captured on accepted start.
- dst_addr  in  CL_ADDR_WIDTH  first destination line address; captured on accepted start.
- size  in  CL_ADDR_WIDTH  line count; captured on accepted start.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE; held until the next accepted start.
- err  out  1  sticky protocol error; cleared only by rst or an accepted start.
- rd_req_valid  out  1  read request valid.
- rd_req_addr  out  CL_ADDR_WIDTH  read line address.
- rd_req_ready  in  1  shim accepts the read request this cycle.
- rd_rsp_valid  in  1  one read line returned into the buffer.
- wr_req_valid  out  1  write request valid; the buffer head line is the write data.
- wr_req_addr  out  CL_ADDR_WIDTH  write line address.
- wr_req_ready  in  1  shim accepts the write request this cycle.
- wr_rsp_valid  in  1  one write completion.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - state=IDLE; all counters 0.
  - busy=0, done=0, err=0, rd_req_valid=0, wr_req_valid=0.
  - rd_req_addr=0, wr_req_addr=0.
  - rst mid-job aborts immediately with no drain; in-flight responses arriving after reset set err (IDLE rule below).
- States:
  - IDLE: start=1 captures addr/size, clears err, goes to RUN. If size==0, goes directly to DONE.
  - RUN: issues reads and writes. Moves to DRAIN when wr_issued==size.
  - DRAIN: waits until wr_rsp_cnt==size, then goes to DONE.
  - DONE: done=1. start=1 behaves as in IDLE.
- Counters:
  - rd_issued, rd_rsp_cnt, wr_issued, wr_rsp_cnt are all CL_ADDR_WIDTH wide.
  - inflight = rd_issued - wr_issued; CNT_WIDTH wide, up/down.
  - buffered = rd_rsp_cnt - wr_issued; CNT_WIDTH wide, up/down.
- Read issue:
  - rd_req_valid = RUN && rd_issued<size && inflight<MAX_OUTSTANDING.
  - rd_req_addr = src_base + rd_issued.
  - Once valid is asserted, the address and valid hold until ready.
- Write issue:
  - wr_req_valid = RUN && buffered>0.
  - wr_req_addr = dst_base + wr_issued.
- Handshakes:
  - A request is transferred on valid&&ready in the same cycle; the counter increments at that posedge.
  - Reads and writes may both transfer in one cycle. inflight then nets to 0 change.
  - rd_rsp_valid and a write transfer in the same cycle leave buffered unchanged.
- Latency:
  - First rd_req_valid appears the cycle after start.
  - A write can issue the cycle after the rd_rsp_valid that fills the buffer.
  - done rises the cycle after the final wr_rsp_valid.
- Address arithmetic: modulo 2^CL_ADDR_WIDTH; wrap is silent and not an error.
- Errors (set err; never block progress):
  - rd_rsp_valid with rd_rsp_cnt==rd_issued.
  - wr_rsp_valid with wr_rsp_cnt==wr_issued.
  - Any response while in IDLE or DONE.
- start while busy is ignored; no effect on the running job.

Decomposition:
- Package dma_seq_pkg:
  - state_t enum {IDLE, RUN, DRAIN, DONE}, 2-bit.
  - localparam DEFAULT_MAX_OUTSTANDING=16.
- Sub-module dma_updown_cnt:
  - Parameterised width; inc/dec inputs; simultaneous inc+dec holds the value; sync clear.
  - Instantiated twice, for inflight and buffered.

Test Plan:
- Basic copy: size=4, src=0x100, dst=0x200, ready always 1, rsp 3 cycles after req → reads 0x100–0x103, writes 0x200–0x203 in order, done=1 one cycle after the 4th wr_rsp, err=0.
- Backpressure: size=40, MAX_OUTSTANDING=16, rd_rsp held off 50 cycles → exactly 16 reads issue, then rd_req_valid=0; reads resume only as writes issue; inflight never exceeds 16.
- Zero size and restart: size=0 start → DONE next cycle with no requests. Start again with size=2 → normal job, done drops on accept.
- Simultaneous events: rd_req transfer, rd_rsp, and wr_req transfer in the same cycle → inflight and buffered both unchanged; final counts equal size.
- Error and wrap: an extra wr_rsp_valid in DONE → err=1 sticky, cleared by next start. src=2^42-2, size=4 → read addresses ...FFE, ...FFF, 0x0, 0x1.
- Reset mid-job: rst at the 5th cycle of RUN → next cycle all outputs at reset values; a subsequent start with size=3 completes correctly.
